// File: rtl/sr_latch_arbiter_if.sv
// sr_latch_arbiter_if
//   Bundles the requester handshake and the latch drive/readback signals that
//   pass between client logic and the sr_latch_arbiter.
//   Signals:
//     req_set / req_clr  level requests from the clients, one bit per requester
//     done               one-hot completion pulse, one bit per requester
//     ok / err           readback verdict, qualified by done
//     busy               arbiter is in the middle of an operation
//     s / r              drive to the latch set/reset inputs
//     q / qn             readback from the latch outputs
//   Modports:
//     master  client/latch side (drives requests and latch readback)
//     slave   arbiter side
interface sr_latch_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0] req_set;
    logic [NUM_REQ-1:0] req_clr;
    logic [NUM_REQ-1:0] done;
    logic               ok;
    logic               err;
    logic               busy;
    logic               s;
    logic               r;
    logic               q;
    logic               qn;

    modport master (
        output req_set, req_clr, q, qn,
        input  done, ok, err, busy, s, r
    );

    modport slave (
        input  req_set, req_clr, q, qn,
        output done, ok, err, busy, s, r
    );
endinterface

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter
//   Shares one SR latch between NUM_REQ requesters. A valid request (exactly
//   one of req_set[i]/req_clr[i] high) is granted round-robin; the arbiter then
//   drives a PULSE_CYCLES-long pulse on s or r, waits GAP_CYCLES with both low,
//   reads q/qn back and reports done[i] together with ok or err.
//   s and r are decoded from the registered state and operation bit, so they
//   can never be high together, not even around reset.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   sr_latch_arbiter_if.slave: requests, done/ok/err/busy, s/r, q/qn
module sr_latch_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_latch_arbiter_if.slave    bus
);
    localparam int  PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int  CNT_MAX   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int  CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam bit  HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [PW-1:0]  cur_q,   cur_d;
    logic           op_q,    op_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] valid;
    logic [PW:0]        cand_sum   [NUM_REQ];
    logic [PW-1:0]      cand_idx   [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;
    logic               grant_found;
    logic [PW-1:0]      grant_idx;
    logic               readback_ok;
    logic               in_check;

    // Candidate gi is the requester gi positions after rr_ptr (wrapping), so
    // cand_valid is the request vector rotated to start at the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign valid[gi]      = bus.req_set[gi] ^ bus.req_clr[gi];
            assign cand_sum[gi]   = {1'b0, rr_ptr_q} + (PW + 1)'(gi);
            assign cand_idx[gi]   = (cand_sum[gi] >= (PW + 1)'(NUM_REQ))
                                  ? PW'(cand_sum[gi] - (PW + 1)'(NUM_REQ))
                                  : PW'(cand_sum[gi]);
            assign cand_valid[gi] = valid[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the candidate nearest the pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            op_q     <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            op_q     <= op_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        op_d     = op_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    cur_d   = grant_idx;
                    op_d    = bus.req_set[grant_idx];
                    cnt_d   = PULSE_LOAD;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                // The serviced requester drops to lowest priority next round.
                rr_ptr_d = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_check    = (state_q == ST_CHECK);
    assign readback_ok = op_q ? ( bus.q && !bus.qn)
                              : (!bus.q &&  bus.qn);

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_done
            assign bus.done[gi] = in_check && (cur_q == PW'(gi));
        end
    endgenerate

    assign bus.s    = (state_q == ST_PULSE) &&  op_q;
    assign bus.r    = (state_q == ST_PULSE) && !op_q;
    assign bus.ok   = in_check &&  readback_ok;
    assign bus.err  = in_check && !readback_ok;
    assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_latch_arbiter.sv
module tb_sr_latch_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q_m = 1'b0;
    logic stuck = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   sr_viol = 0;

    sr_latch_arbiter_if #(.NUM_REQ(4)) bus ();

    sr_latch_arbiter #(
        .NUM_REQ(4),
        .PULSE_CYCLES(2),
        .GAP_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural latch: set/reset take effect on the clock edge; stuck forces q=0.
    always @(posedge clk) begin
        if (stuck)      q_m <= 1'b0;
        else if (bus.s) q_m <= 1'b1;
        else if (bus.r) q_m <= 1'b0;
    end
    assign bus.q  = q_m;
    assign bus.qn = ~q_m;

    always @(negedge clk or posedge rst or negedge rst) begin
        if (bus.s && bus.r) sr_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(output logic [3:0] d, output logic o, output logic e, output int cyc);
        d = 4'b0; o = 1'b0; e = 1'b0; cyc = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (|bus.done) begin
                d = bus.done; o = bus.ok; e = bus.err; cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_set = 4'b0;
        bus.req_clr = 4'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.busy, bus.s, bus.r, bus.done, bus.ok, bus.err} !== 9'b0)
            $display("FAIL reset_outputs: got %b want 000000000",
                     {bus.busy, bus.s, bus.r, bus.done, bus.ok, bus.err});
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single_set();
        bus.req_set = 4'b0001;
        step();
        total_cnt++;
        if ({bus.s, bus.r, bus.busy} !== 3'b101) $display("FAIL set_pulse1: s,r,busy got %b want 101", {bus.s, bus.r, bus.busy});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.s, bus.r} !== 2'b10) $display("FAIL set_pulse2: s,r got %b want 10", {bus.s, bus.r});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.s, bus.r, bus.done} !== 6'b0) $display("FAIL set_gap: s,r,done got %b want 000000", {bus.s, bus.r, bus.done});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.done, bus.ok, bus.err} !== 6'b000110) $display("FAIL set_done: done,ok,err got %b want 000110", {bus.done, bus.ok, bus.err});
        else pass_cnt++;
        bus.req_set = 4'b0;
        step();
        total_cnt++;
        if ({bus.busy, bus.done, bus.q} !== 6'b000001) $display("FAIL set_idle_q: busy,done,q got %b want 000001", {bus.busy, bus.done, bus.q});
        else pass_cnt++;
        $display("test_single_set done");
    endtask

    task automatic test_alternate();
        logic [3:0] exp_seq [4];
        logic [3:0] d; logic o, e; int cyc;
        exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        bus.req_set = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, o, e, cyc);
            total_cnt++;
            if (d !== exp_seq[k] || o !== 1'b1 || e !== 1'b0)
                $display("FAIL alt_grant%0d: done=%b ok=%b err=%b want done=%b ok=1 err=0", k, d, o, e, exp_seq[k]);
            else pass_cnt++;
            total_cnt++;
            if (cyc !== ((k == 0) ? 4 : 5))
                $display("FAIL alt_latency%0d: cycles got %0d want %0d", k, cyc, (k == 0) ? 4 : 5);
            else pass_cnt++;
        end
        bus.req_set = 4'b0;
        step();
        total_cnt++;
        if (sr_viol !== 0) $display("FAIL alt_sr_overlap: count got %0d want 0", sr_viol);
        else pass_cnt++;
        $display("test_alternate done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [4];
        logic [3:0] d; logic o, e; int cyc;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req_set = 4'b0001;
        wait_done(d, o, e, cyc);
        total_cnt++;
        if (d !== 4'b0001) $display("FAIL rr_prime: done got %b want 0001", d);
        else pass_cnt++;
        bus.req_set = 4'b0;
        bus.req_clr = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, o, e, cyc);
            total_cnt++;
            if (d !== exp_seq[k] || o !== 1'b1 || e !== 1'b0)
                $display("FAIL rr_grant%0d: done=%b ok=%b err=%b want done=%b ok=1 err=0", k, d, o, e, exp_seq[k]);
            else pass_cnt++;
        end
        bus.req_clr = 4'b0;
        step();
        total_cnt++;
        if (bus.q !== 1'b0) $display("FAIL rr_q_final: q got %b want 0", bus.q);
        else pass_cnt++;
        $display("test_round_robin done");
    endtask

    task automatic test_illegal();
        logic [3:0] d; logic o, e; int cyc;
        logic bad;
        bad = 1'b0;
        bus.req_set = 4'b0010;
        bus.req_clr = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.busy || bus.s || bus.r || (|bus.done)) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0) $display("FAIL illegal_idle: activity flag got %b want 0", bad);
        else pass_cnt++;
        bus.req_clr = 4'b1010;
        wait_done(d, o, e, cyc);
        total_cnt++;
        if (d !== 4'b1000 || o !== 1'b1 || e !== 1'b0)
            $display("FAIL illegal_then_valid: done=%b ok=%b err=%b want done=1000 ok=1 err=0", d, o, e);
        else pass_cnt++;
        bus.req_set = 4'b0;
        bus.req_clr = 4'b0;
        step();
        $display("test_illegal done");
    endtask

    task automatic test_stuck();
        logic [3:0] d; logic o, e; int cyc;
        stuck = 1'b1;
        bus.req_set = 4'b1000;
        wait_done(d, o, e, cyc);
        total_cnt++;
        if (d !== 4'b1000 || o !== 1'b0 || e !== 1'b1)
            $display("FAIL stuck_err: done=%b ok=%b err=%b want done=1000 ok=0 err=1", d, o, e);
        else pass_cnt++;
        bus.req_set = 4'b0;
        step();
        stuck = 1'b0;
        $display("test_stuck done");
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] d; logic o, e; int cyc;
        logic bad;
        do_reset();
        bus.req_set = 4'b0010;
        wait_done(d, o, e, cyc);
        total_cnt++;
        if (d !== 4'b0010) $display("FAIL mid_prime: done got %b want 0010", d);
        else pass_cnt++;
        bus.req_set = 4'b0100;
        step();
        step();
        total_cnt++;
        if ({bus.s, bus.busy} !== 2'b11) $display("FAIL mid_pulse: s,busy got %b want 11", {bus.s, bus.busy});
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.s, bus.r, bus.busy} !== 3'b000) $display("FAIL mid_reset_drop: s,r,busy got %b want 000", {bus.s, bus.r, bus.busy});
        else pass_cnt++;
        bus.req_set = 4'b1111;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if ((|bus.done) || bus.s || bus.r) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0) $display("FAIL mid_reset_quiet: activity flag got %b want 0", bad);
        else pass_cnt++;
        rst = 1'b0;
        wait_done(d, o, e, cyc);
        total_cnt++;
        if (d !== 4'b0001 || o !== 1'b1 || cyc !== 4)
            $display("FAIL mid_rrptr0: done=%b ok=%b cycles=%0d want done=0001 ok=1 cycles=4", d, o, cyc);
        else pass_cnt++;
        bus.req_set = 4'b0;
        step();
        step();
        total_cnt++;
        if (sr_viol !== 0) $display("FAIL sr_overlap_total: count got %0d want 0", sr_viol);
        else pass_cnt++;
        $display("test_reset_mid_op done");
    endtask

    initial begin
        bus.req_set = 4'b0;
        bus.req_clr = 4'b0;
        test_reset();
        test_single_set();
        test_alternate();
        test_round_robin();
        test_illegal();
        test_stuck();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
